alu_issue_ctrl: RTL and testbench

Upstream issue/write-back controller for the 8-bit registered ALU (ADD/SUB, one-cycle registered latency). It accepts instructions over a valid/ready handshake and holds a 4-entry register file. For ALU ops it drives operands and opcode to the ALU, then captures the ALU result one cycle later and writes it back. Load-immediate and output instructions are executed locally.

---
 rtl/alu_issue_ctrl_if.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 97 +++++++++
 tb/tb_alu_issue_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction handshake, ALU operand/result bus and status outputs
// of the ALU issue/write-back controller.
interface alu_issue_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [3:0]            instr_op;
    logic [1:0]            instr_dst;
    logic [1:0]            instr_src_a;
    logic [1:0]            instr_src_b;
    logic [DATA_WIDTH-1:0] instr_imm;
    logic [DATA_WIDTH-1:0] alu_operand_a;
    logic [DATA_WIDTH-1:0] alu_operand_b;
    logic [3:0]            alu_opcode;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  err_illegal;
    logic [CNT_WIDTH-1:0]  retired_count;

    // Controller side.
    modport slave (
        input  instr_valid, instr_op, instr_dst, instr_src_a, instr_src_b, instr_imm,
        input  alu_result,
        output instr_ready, alu_operand_a, alu_operand_b, alu_opcode,
        output out_valid, out_data, err_illegal, retired_count
    );

    // Instruction source / ALU / observer side.
    modport master (
        output instr_valid, instr_op, instr_dst, instr_src_a, instr_src_b, instr_imm,
        output alu_result,
        input  instr_ready, alu_operand_a, alu_operand_b, alu_opcode,
        input  out_valid, out_data, err_illegal, retired_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for a one-cycle registered ALU: 4-entry register
// file, LDI/OUT executed locally, ADD/SUB sent to the ALU and written back.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_ctrl_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_LDI = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1001;

    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t                      state_q, state_d;
    logic [3:0][DATA_WIDTH-1:0]  regs_q;
    logic [1:0]                  dst_q;
    logic [DATA_WIDTH-1:0]       opa_q, opb_q;
    logic [3:0]                  opc_q;
    logic                        out_vld_q;
    logic [DATA_WIDTH-1:0]       out_data_q;
    logic                        err_q;
    logic [CNT_WIDTH-1:0]        retired_q;

    logic accept, is_alu, is_ldi, is_out;

    assign bus.instr_ready = (state_q == IDLE);
    assign accept = bus.instr_valid && (state_q == IDLE);
    assign is_alu = (bus.instr_op == OP_ADD) || (bus.instr_op == OP_SUB);
    assign is_ldi = (bus.instr_op == OP_LDI);
    assign is_out = (bus.instr_op == OP_OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_alu) state_d = ISSUE;
            ISSUE:   state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accepts only happen in IDLE and write-back only in WB, so the two never
    // compete for the register file or the retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            dst_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            opc_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            err_q      <= 1'b0;
            retired_q  <= '0;
        end else begin
            out_vld_q <= 1'b0;
            if (accept) begin
                if (is_alu) begin
                    opa_q <= regs_q[bus.instr_src_a];
                    opb_q <= regs_q[bus.instr_src_b];
                    opc_q <= bus.instr_op;
                    dst_q <= bus.instr_dst;
                end else if (is_ldi) begin
                    regs_q[bus.instr_dst] <= bus.instr_imm;
                    retired_q             <= retired_q + CNT_WIDTH'(1);
                end else if (is_out) begin
                    out_data_q <= regs_q[bus.instr_src_a];
                    out_vld_q  <= 1'b1;
                    retired_q  <= retired_q + CNT_WIDTH'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == WB) begin
                regs_q[dst_q] <= bus.alu_result;
                retired_q     <= retired_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.alu_operand_a = opa_q;
    assign bus.alu_operand_b = opb_q;
    assign bus.alu_opcode    = opc_q;
    assign bus.out_valid     = out_vld_q;
    assign bus.out_data      = out_data_q;
    assign bus.err_illegal   = err_q;
    assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: instruction table with a scoreboard of
// expected OUT values, plus hand sequences for stalls, illegal ops and mid-op reset.
module tb_alu_issue_ctrl;
    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] LDI = 4'b1000;
    localparam logic [3:0] OUT = 4'b1001;
    localparam logic [3:0] ILL = 4'b0101;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();

    alu_issue_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered ALU model: samples operands at the edge closing ISSUE.
    always @(posedge clk) begin
        case (bus.alu_opcode)
            ADD:     bus.alu_result <= bus.alu_operand_a + bus.alu_operand_b;
            SUB:     bus.alu_result <= bus.alu_operand_a - bus.alu_operand_b;
            default: bus.alu_result <= 8'h00;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [1:0] dst;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [7:0] imm;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[16];
    logic [7:0] sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         exp_retired = 0;
    int         run = 0;
    int         max_run = 0;
    int         w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor pops the scoreboard on each out_valid cycle.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            run++;
            if (sb_q.size() == 0) chk("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
            else                  chk("out_data", 32'(bus.out_data), 32'(sb_q.pop_front()));
        end else begin
            if (run > max_run) max_run = run;
            run = 0;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge with
    // instr_valid still high, so consecutive calls issue back-to-back.
    task automatic send(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [7:0] imm, input logic [7:0] exp,
                        output int waits);
        bus.instr_op    = op;
        bus.instr_dst   = dst;
        bus.instr_src_a = sa;
        bus.instr_src_b = sb;
        bus.instr_imm   = imm;
        bus.instr_valid = 1'b1;
        waits = 0;
        while (bus.instr_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (bus.instr_ready !== 1'b1) begin
            chk("accept_timeout", 32'(bus.instr_ready), 32'd1);
            return;
        end
        if (op == OUT) sb_q.push_back(exp);
        if (op == ADD || op == SUB || op == LDI || op == OUT) exp_retired++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.instr_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{LDI, 2'd0, 2'd0, 2'd0, 8'h05, 8'h00};
        tbl[1]  = '{LDI, 2'd1, 2'd0, 2'd0, 8'h03, 8'h00};
        tbl[2]  = '{ADD, 2'd2, 2'd0, 2'd1, 8'h00, 8'h00};
        tbl[3]  = '{OUT, 2'd0, 2'd2, 2'd0, 8'h00, 8'h08};
        tbl[4]  = '{LDI, 2'd0, 2'd0, 2'd0, 8'h03, 8'h00};
        tbl[5]  = '{LDI, 2'd1, 2'd0, 2'd0, 8'h05, 8'h00};
        tbl[6]  = '{SUB, 2'd3, 2'd0, 2'd1, 8'h00, 8'h00};
        tbl[7]  = '{OUT, 2'd0, 2'd3, 2'd0, 8'h00, 8'hFE};
        tbl[8]  = '{LDI, 2'd0, 2'd0, 2'd0, 8'hFF, 8'h00};
        tbl[9]  = '{LDI, 2'd1, 2'd0, 2'd0, 8'h01, 8'h00};
        tbl[10] = '{ADD, 2'd2, 2'd0, 2'd1, 8'h00, 8'h00};
        tbl[11] = '{OUT, 2'd0, 2'd2, 2'd0, 8'h00, 8'h00};
        tbl[12] = '{LDI, 2'd0, 2'd0, 2'd0, 8'h07, 8'h00};
        tbl[13] = '{ADD, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00};
        tbl[14] = '{OUT, 2'd0, 2'd0, 2'd0, 8'h00, 8'h0E};
        tbl[15] = '{OUT, 2'd0, 2'd0, 2'd0, 8'h00, 8'h0E};

        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_op = '0; bus.instr_dst = '0; bus.instr_src_a = '0;
        bus.instr_src_b = '0; bus.instr_imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_err", 32'(bus.err_illegal), 32'd0);
        chk("rst_retired", 32'(bus.retired_count), 32'd0);
        chk("rst_alu_ops", {bus.alu_operand_a, bus.alu_operand_b, 4'h0, bus.alu_opcode}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            send(tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].imm, tbl[i].exp, w);
        idle(3);
        chk("retired_after_add", 32'(bus.retired_count), 32'd4);

        max_run = 0;
        for (int i = 4; i < 16; i++)
            send(tbl[i].op, tbl[i].dst, tbl[i].sa, tbl[i].sb, tbl[i].imm, tbl[i].exp, w);
        idle(3);
        chk("retired_after_table", 32'(bus.retired_count), 32'(exp_retired));
        chk("b2b_out_run", 32'(max_run), 32'd2);
        chk("err_clear", 32'(bus.err_illegal), 32'd0);

        // Illegal op: sticky flag, no state change (r0 still 0x0E).
        send(ILL, 2'd0, 2'd1, 2'd2, 8'hAA, 8'h00, w);
        idle(2);
        chk("err_set", 32'(bus.err_illegal), 32'd1);
        chk("retired_illegal", 32'(bus.retired_count), 32'(exp_retired));
        send(LDI, 2'd1, 2'd0, 2'd0, 8'h09, 8'h00, w);
        send(OUT, 2'd0, 2'd1, 2'd0, 8'h00, 8'h09, w);
        send(OUT, 2'd0, 2'd0, 2'd0, 8'h00, 8'h0E, w);
        idle(3);
        chk("err_sticky", 32'(bus.err_illegal), 32'd1);
        chk("retired_post_illegal", 32'(bus.retired_count), 32'(exp_retired));

        // Valid held high across dependent ALU ops: two stall cycles each.
        send(LDI, 2'd0, 2'd0, 2'd0, 8'h0A, 8'h00, w);
        send(LDI, 2'd1, 2'd0, 2'd0, 8'h04, 8'h00, w);
        send(SUB, 2'd3, 2'd0, 2'd1, 8'h00, 8'h00, w);
        chk("ready_low_after_sub", 32'(bus.instr_ready), 32'd0);
        send(ADD, 2'd2, 2'd3, 2'd0, 8'h00, 8'h00, w);
        chk("stall_sub", 32'(w), 32'd2);
        send(OUT, 2'd0, 2'd2, 2'd0, 8'h00, 8'h10, w);
        chk("stall_add", 32'(w), 32'd2);
        send(OUT, 2'd0, 2'd3, 2'd0, 8'h00, 8'h06, w);
        idle(3);
        chk("retired_held_valid", 32'(bus.retired_count), 32'(exp_retired));

        // Reset while ADD r1 is in ISSUE; late ALU result must be dropped.
        send(ADD, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00, w);
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_opa", 32'(bus.alu_operand_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = 0;
        #1;
        chk("midrst_ready", 32'(bus.instr_ready), 32'd1);
        idle(2);
        chk("midrst_retired", 32'(bus.retired_count), 32'd0);
        chk("midrst_err", 32'(bus.err_illegal), 32'd0);
        for (int r = 0; r < 4; r++)
            send(OUT, 2'd0, 2'(r), 2'd0, 8'h00, 8'h00, w);
        idle(3);
        chk("retired_final", 32'(bus.retired_count), 32'd4);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
